// File: rtl/vga_timing_pkg.sv
// Default 640x480@60Hz timing constants shared by the VGA sync generator and its users.
// Sync bounds are inclusive pixel/line numbers.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  localparam int CLK_DIV_DEF = 4;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOT_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HS_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

  function automatic logic in_span(input logic [COORD_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// System-clock to pixel-rate divider: div_cnt runs 0..CLK_DIV-1, pixel_tick is high while div_cnt==CLK_DIV-1.
// The first tick after reset release lands on clock edge CLK_DIV-1.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;

  always_comb begin
    div_next = div_cnt + DIV_W'(1);
    if (div_cnt == DIV_LAST) div_next = '0;
  end

  // Tick registered from the next count: same timing as a decode of div_cnt, but
  // guaranteed low during reset even when CLK_DIV=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      pixel_tick <= 1'b0;
    end else begin
      div_cnt    <= div_next;
      pixel_tick <= (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel/line counters advanced on pixel_tick, registered active-low syncs
// aligned with the counters, visible-area flag and a frame-start pulse.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pixel_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS_C = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0] V_VIS_C = COORD_W'(V_VIS);

  if (H_TOT > COORD_MAX || V_TOT > COORD_MAX) begin : g_tot_check
    $error("vga_sync_gen: H_TOT/V_TOT exceed 10-bit coordinate range");
  end

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;

  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk       (clk),
    .reset     (reset),
    .pixel_tick(pixel_tick)
  );

  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (pixel_tick) begin
      if (pixel_x == H_LAST) begin
        x_next = '0;
        if (pixel_y == V_LAST) y_next = '0;
        else                   y_next = pixel_y + COORD_W'(1);
      end else begin
        x_next = pixel_x + COORD_W'(1);
      end
    end
  end

  // Syncs decode the next counter values so they change on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      pixel_x <= x_next;
      pixel_y <= y_next;
      hsync   <= ~in_span(x_next, HS_START, HS_END);
      vsync   <= ~in_span(y_next, VS_START, VS_END);
    end
  end

  assign video_on    = (pixel_x < H_VIS_C) && (pixel_y < V_VIS_C);
  assign frame_start = pixel_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size timing at CLK_DIV=4 for line/hsync/reset behaviour, and a
// shrunken-timing instance at CLK_DIV=1 so whole frames fit in a short run.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
  } obs_t;

  localparam int B_HVIS = 16, B_HFP = 2, B_HSW = 4, B_HBP = 3;
  localparam int B_VVIS = 12, B_VFP = 2, B_VSW = 2, B_VBP = 3;
  localparam int B_HTOT = B_HVIS + B_HFP + B_HSW + B_HBP;
  localparam int B_VTOT = B_VVIS + B_VFP + B_VSW + B_VBP;
  localparam int B_FRAME = B_HTOT * B_VTOT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic       tick_a, hs_a, vs_a, von_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       tick_b, hs_b, vs_b, von_b, fs_b;
  logic [9:0] x_b, y_b;

  vga_sync_gen #(.CLK_DIV(4)) dut_a (
    .clk(clk), .reset(reset_a), .pixel_tick(tick_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .pixel_x(x_a), .pixel_y(y_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VIS(B_HVIS), .H_FP(B_HFP), .H_SYNC(B_HSW), .H_BP(B_HBP),
    .V_VIS(B_VVIS), .V_FP(B_VFP), .V_SYNC(B_VSW), .V_BP(B_VBP)
  ) dut_b (
    .clk(clk), .reset(reset_b), .pixel_tick(tick_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .pixel_x(x_b), .pixel_y(y_b), .frame_start(fs_b)
  );

  obs_t q_a[$];
  obs_t q_b[$];
  int   k_a = 0;
  int   k_b = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // Closed-form reference: k = clock edges since reset release.
  function automatic obs_t model(input int k, input int d, input int hvis, input int hfp,
                                 input int hsw, input int hbp, input int vvis, input int vfp,
                                 input int vsw, input int vbp);
    obs_t e;
    int htot, vtot, p, x, y;
    htot = hvis + hfp + hsw + hbp;
    vtot = vvis + vfp + vsw + vbp;
    if (k == 0)      p = 0;
    else if (d == 1) p = k - 1;
    else             p = k / d;
    x = p % htot;
    y = (p / htot) % vtot;
    e.tick = (k >= 1) && ((k % d) == d - 1);
    e.hs   = !((x >= hvis + hfp) && (x <= hvis + hfp + hsw - 1));
    e.vs   = !((y >= vvis + vfp) && (y <= vvis + vfp + vsw - 1));
    e.von  = (x < hvis) && (y < vvis);
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.fs   = e.tick && (x == htot - 1) && (y == vtot - 1);
    return e;
  endfunction

  function automatic obs_t obs_a();
    return {tick_a, hs_a, vs_a, von_a, x_a, y_a, fs_a};
  endfunction

  function automatic obs_t obs_b();
    return {tick_b, hs_b, vs_b, von_b, x_b, y_b, fs_b};
  endfunction

  task automatic edge_a();
    @(posedge clk);
    if (reset_a) k_a = 0;
    else         k_a++;
    q_a.push_back(model(k_a, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    #1;
  endtask

  task automatic edge_b();
    @(posedge clk);
    if (reset_b) k_b = 0;
    else         k_b++;
    q_b.push_back(model(k_b, 1, B_HVIS, B_HFP, B_HSW, B_HBP, B_VVIS, B_VFP, B_VSW, B_VBP));
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    reset_a = 1'b1;
    reset_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_a();
      e = q_a.pop_front(); o = obs_a(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_a k=%0d got=%h exp=%h", k_a, o, e);
      end
    end
    vectors++;
    if ({tick_b, hs_b, vs_b, von_b, x_b, y_b, fs_b} !== {1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_b_div1 got tick=%b hs=%b vs=%b von=%b x=%0d y=%0d fs=%b exp 0 1 1 1 0 0 0",
               tick_b, hs_b, vs_b, von_b, x_b, y_b, fs_b);
    end
    reset_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      edge_a();
      e = q_a.pop_front(); o = obs_a(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL startup k=%0d got=%h exp=%h", k_a, o, e);
      end
      if (k_a == 3) begin
        vectors++;
        if (tick_a !== 1'b1) begin
          miscompares++;
          $display("FAIL first_tick got=%b exp=1", tick_a);
        end
      end
      if (k_a == 4) begin
        vectors++;
        if (x_a !== 10'd1) begin
          miscompares++;
          $display("FAIL first_advance x got=%0d exp=1", x_a);
        end
      end
    end
  endtask

  task automatic test_line();
    obs_t e, o;
    logic [9:0] prev_x, prev_y;
    int line_ticks, blank_ticks;
    bit wrapped;
    line_ticks = 0; blank_ticks = 0; wrapped = 0;
    prev_x = x_a; prev_y = y_a;
    for (int i = 0; i < 8000 && y_a != 10'd2; i++) begin
      edge_a();
      e = q_a.pop_front(); o = obs_a(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL line k=%0d got=%h exp=%h", k_a, o, e);
      end
      if (o.y == 10'd1 && prev_y == 10'd0) begin
        wrapped = 1;
        vectors++;
        if (prev_x !== 10'd799 || o.x !== 10'd0) begin
          miscompares++;
          $display("FAIL line_wrap x %0d->%0d exp 799->0", prev_x, o.x);
        end
      end
      if (o.y == 10'd1 && o.tick) begin
        line_ticks++;
        if (!o.von) blank_ticks++;
      end
      prev_x = o.x; prev_y = o.y;
    end
    vectors++;
    if (!wrapped || y_a !== 10'd2) begin
      miscompares++;
      $display("FAIL line_timeout wrapped=%0d y=%0d exp wrap and y=2", wrapped, y_a);
    end
    vectors++;
    if (line_ticks != 800) begin
      miscompares++;
      $display("FAIL ticks_per_line got=%0d exp=800", line_ticks);
    end
    vectors++;
    if (blank_ticks != 160) begin
      miscompares++;
      $display("FAIL blank_ticks got=%0d exp=160", blank_ticks);
    end
  endtask

  task automatic test_hsync();
    obs_t e, o;
    logic prev_hs;
    int fall_x, rise_x, low_ticks;
    fall_x = -1; rise_x = -1; low_ticks = 0;
    prev_hs = hs_a;
    for (int i = 0; i < 4000 && y_a != 10'd3; i++) begin
      edge_a();
      e = q_a.pop_front(); o = obs_a(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL hsync_run k=%0d got=%h exp=%h", k_a, o, e);
      end
      if (prev_hs && !o.hs) fall_x = int'(o.x);
      if (!prev_hs && o.hs) rise_x = int'(o.x);
      if (!o.hs && o.tick) low_ticks++;
      prev_hs = o.hs;
    end
    vectors++;
    if (fall_x != 656) begin
      miscompares++;
      $display("FAIL hsync_fall x got=%0d exp=656", fall_x);
    end
    vectors++;
    if (rise_x != 752) begin
      miscompares++;
      $display("FAIL hsync_rise x got=%0d exp=752", rise_x);
    end
    vectors++;
    if (low_ticks != 96) begin
      miscompares++;
      $display("FAIL hsync_width got=%0d exp=96", low_ticks);
    end
  endtask

  task automatic test_midframe_reset();
    obs_t e, o;
    int first_tick;
    for (int i = 0; i < 4000 && !(x_a == 10'd300 && y_a == 10'd3); i++) begin
      edge_a();
      e = q_a.pop_front(); o = obs_a(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL pre_reset k=%0d got=%h exp=%h", k_a, o, e);
      end
    end
    vectors++;
    if (x_a !== 10'd300 || y_a !== 10'd3) begin
      miscompares++;
      $display("FAIL reach_300_3 got x=%0d y=%0d exp 300 3", x_a, y_a);
    end
    reset_a = 1'b1;
    edge_a();
    e = q_a.pop_front(); o = obs_a(); vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL midframe_reset got=%h exp=%h", o, e);
    end
    vectors++;
    if (x_a !== 10'd0 || y_a !== 10'd0 || hs_a !== 1'b1 || vs_a !== 1'b1 || tick_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values got x=%0d y=%0d hs=%b vs=%b tick=%b exp 0 0 1 1 0",
               x_a, y_a, hs_a, vs_a, tick_a);
    end
    reset_a = 1'b0;
    first_tick = -1;
    for (int i = 1; i <= 8; i++) begin
      edge_a();
      e = q_a.pop_front(); o = obs_a(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL post_reset k=%0d got=%h exp=%h", k_a, o, e);
      end
      if (o.tick && first_tick < 0) first_tick = i + 1;
    end
    vectors++;
    if (first_tick != 4) begin
      miscompares++;
      $display("FAIL div_restart clks_from_reset got=%0d exp=4", first_tick);
    end
  endtask

  task automatic test_frame_div1();
    obs_t e, o;
    int n, fs_count, fs_k0, fs_k1, vs_low, tick_count;
    bit after_fs;
    n = 2 * B_FRAME + 20;
    fs_count = 0; fs_k0 = -1; fs_k1 = -1; vs_low = 0; tick_count = 0; after_fs = 0;
    @(negedge clk);
    reset_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      edge_b();
      e = q_b.pop_front(); o = obs_b(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL frame_b k=%0d got=%h exp=%h", k_b, o, e);
      end
      if (after_fs) begin
        vectors++;
        if (o.x !== 10'd0 || o.y !== 10'd0) begin
          miscompares++;
          $display("FAIL after_frame_start got x=%0d y=%0d exp 0 0", o.x, o.y);
        end
        after_fs = 0;
      end
      if (o.tick) tick_count++;
      if (!o.vs && k_b <= B_FRAME) vs_low++;
      if (o.fs) begin
        fs_count++;
        if (fs_k0 < 0) fs_k0 = k_b;
        else if (fs_k1 < 0) fs_k1 = k_b;
        after_fs = 1;
      end
    end
    vectors++;
    if (tick_count != n) begin
      miscompares++;
      $display("FAIL div1_tick_const got=%0d exp=%0d", tick_count, n);
    end
    vectors++;
    if (fs_count != 2) begin
      miscompares++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_count);
    end
    vectors++;
    if (fs_k1 - fs_k0 != B_FRAME) begin
      miscompares++;
      $display("FAIL frame_period got=%0d exp=%0d", fs_k1 - fs_k0, B_FRAME);
    end
    vectors++;
    if (vs_low != B_VSW * B_HTOT) begin
      miscompares++;
      $display("FAIL vsync_low_ticks got=%0d exp=%0d", vs_low, B_VSW * B_HTOT);
    end
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    test_reset();
    test_line();
    test_hsync();
    test_midframe_reset();
    test_frame_div1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
